// File: rtl/pn_seq_checker.sv
// ---------------------------------------------------------------------------
// pn_seq_checker
//
// Purpose: checks a received serial PN stream against the 3-bit LFSR sequence
// s[n] = s[n-1] ^ s[n-3] (period 7: 1,1,1,0,1,0,0 from seed 111). In SEARCH
// it fills a 3-bit history and counts consecutive correct predictions until
// LOCK_CNT of them declare lock. In LOCKED the history is driven by its own
// predictions (flywheel), so a single corrupted input bit yields exactly one
// error. LOSS_CNT consecutive mispredictions drop back to SEARCH.
//
// Parameters:
//   LOCK_CNT    consecutive correct predictions in SEARCH needed for lock
//   LOSS_CNT    consecutive mispredictions in LOCKED needed for loss of lock
//
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   synchronous, active-high; overrides every other input
//   pn_in        in   received serial PN bit
//   pn_valid     in   pn_in is sampled only when high
//   err_clr      in   synchronous clear of error_count
//   locked       out  high while in LOCKED (this is the state register view)
//   bit_error    out  one-cycle pulse per mispredicted bit while LOCKED
//   error_count  out  saturating (255) count of bit errors while LOCKED
//
// Configuration macro: PN_CHK_ERR_CNT_EN
//   defined   -> error_count with saturation and err_clr is built
//   undefined -> error_count is constant 0 and err_clr is ignored
//
// Handshake: a bit is consumed on every rising edge where pn_valid is high;
// there is no back-pressure. With pn_valid low nothing changes and
// bit_error stays low.
// ---------------------------------------------------------------------------
module pn_seq_checker #(
  parameter int LOCK_CNT = 7,
  parameter int LOSS_CNT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pn_in,
  input  logic       pn_valid,
  input  logic       err_clr,
  output logic       locked,
  output logic       bit_error,
  output logic [7:0] error_count
);

  localparam logic [0:0] SEARCH = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  localparam int MW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam int LW = (LOSS_CNT < 2) ? 1 : $clog2(LOSS_CNT + 1);

  logic [0:0]    state;
  // history = {s[n-1], s[n-2], s[n-3]}
  logic [2:0]    hist;
  logic [1:0]    fill;
  logic [MW-1:0] match_cnt;
  logic [LW-1:0] miss_cnt;

  logic pred;
  logic hit;
  logic lock_err;

  assign pred = hist[2] ^ hist[0];
  // An all-zero history predicts zero forever; treat it as a miss so the
  // checker can never lock onto a dead (all-zero) line.
  assign hit  = (pn_in == pred) && (hist != 3'b000);
  // Mispredicted valid bit while locked: drives both bit_error and the counter.
  assign lock_err = pn_valid && (state == LOCKED) && (pn_in != pred);

  assign locked = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SEARCH;
      hist      <= 3'b000;
      fill      <= 2'd0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      bit_error <= 1'b0;
    end else begin
      bit_error <= 1'b0;
      if (pn_valid) begin
        if (state == SEARCH) begin
          hist <= {pn_in, hist[2:1]};
          if (fill != 2'd3) begin
            fill <= fill + 2'd1;
          end else if (hit) begin
            if (match_cnt == MW'(LOCK_CNT - 1)) begin
              state     <= LOCKED;
              match_cnt <= '0;
              miss_cnt  <= '0;
            end else begin
              match_cnt <= match_cnt + MW'(1);
            end
          end else begin
            match_cnt <= '0;
          end
        end else begin
          // Flywheel: advance on our own prediction, not on the received bit.
          hist <= {pred, hist[2:1]};
          if (pn_in != pred) begin
            bit_error <= 1'b1;
            if (miss_cnt == LW'(LOSS_CNT - 1)) begin
              state     <= SEARCH;
              fill      <= 2'd0;
              match_cnt <= '0;
              miss_cnt  <= '0;
            end else begin
              miss_cnt <= miss_cnt + LW'(1);
            end
          end else begin
            miss_cnt <= '0;
          end
        end
      end
    end
  end

`ifdef PN_CHK_ERR_CNT_EN
  logic [7:0] err_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt <= 8'd0;
    end else if (err_clr) begin
      // A clear that coincides with an error keeps that error.
      err_cnt <= lock_err ? 8'd1 : 8'd0;
    end else if (lock_err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign error_count = err_cnt;
`else
  logic unused_cnt_inputs;
  assign unused_cnt_inputs = err_clr ^ lock_err;
  assign error_count = 8'd0;
`endif

endmodule

// File: tb/tb_pn_seq_checker.sv
// ---------------------------------------------------------------------------
// tb_pn_seq_checker
//
// Directed steps followed by a randomized phase, all in one initial block.
// The reference model follows the sequence definition directly: it keeps the
// received bits in a queue while searching and, once locked, walks a phase
// index through the 7-entry PN table.
// ---------------------------------------------------------------------------
module tb_pn_seq_checker;

  localparam int LOCK_N = 7;
  localparam int LOSS_N = 3;

`ifdef PN_CHK_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // clock / reset
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pn_in = 1'b0;
  logic       pn_valid = 1'b0;
  logic       err_clr = 1'b0;
  logic       locked;
  logic       bit_error;
  logic [7:0] error_count;

  always #5 clk = ~clk;

  pn_seq_checker #(.LOCK_CNT(LOCK_N), .LOSS_CNT(LOSS_N)) dut (
    .clk         (clk),
    .reset       (reset),
    .pn_in       (pn_in),
    .pn_valid    (pn_valid),
    .err_clr     (err_clr),
    .locked      (locked),
    .bit_error   (bit_error),
    .error_count (error_count)
  );

  int total = 0;
  int bad = 0;

  // PN table, one period starting at seed 111
  bit pn_tab [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  // reference model state
  bit m_locked;
  bit m_hist[$];
  int m_match;
  int m_miss;
  int m_phase;
  int m_cnt;
  int src;

  // scoreboard queue: expected error_count after each checked edge
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_hist.delete();
    m_match = 0;
    m_miss = 0;
    m_phase = 0;
    m_cnt = 0;
    src = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pn_valid = 1'($urandom_range(0, 1));
    err_clr = 1'($urandom_range(0, 1));
    pn_in = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    model_reset();
    chk("reset_locked", {7'd0, locked}, 8'd0);
    chk("reset_bit_error", {7'd0, bit_error}, 8'd0);
    chk("reset_error_count", error_count, 8'd0);
    reset = 1'b0;
  endtask

  // one clock with given inputs, then model update and output checks
  task automatic step(input logic b, input logic v, input logic c);
    bit pred;
    bit ok;
    bit e;
    pn_in = b;
    pn_valid = v;
    err_clr = c;
    @(posedge clk);
    #1;
    e = 1'b0;
    if (v) begin
      if (!m_locked) begin
        if (m_hist.size() < 3) begin
          m_hist.push_back(b);
        end else begin
          // s[n] = s[n-1] ^ s[n-3]; queue index 2 is newest
          pred = m_hist[2] ^ m_hist[0];
          ok = (b == pred) && (m_hist[0] | m_hist[1] | m_hist[2]);
          void'(m_hist.pop_front());
          m_hist.push_back(b);
          m_match = ok ? m_match + 1 : 0;
          if (m_match == LOCK_N) begin
            m_locked = 1'b1;
            m_miss = 0;
            for (int p = 0; p < 7; p++)
              if (pn_tab[p] == m_hist[0] && pn_tab[(p + 1) % 7] == m_hist[1] &&
                  pn_tab[(p + 2) % 7] == m_hist[2])
                m_phase = (p + 3) % 7;
          end
        end
      end else begin
        pred = pn_tab[m_phase];
        m_phase = (m_phase + 1) % 7;
        if (b != pred) begin
          e = 1'b1;
          m_miss++;
          if (m_miss == LOSS_N) begin
            m_locked = 1'b0;
            m_hist.delete();
            m_match = 0;
            m_miss = 0;
          end
        end else begin
          m_miss = 0;
        end
      end
    end
    if (c) m_cnt = e ? 1 : 0;
    else if (e && m_cnt < 255) m_cnt++;
    exp_q.push_back(CNT_EN ? 8'(m_cnt) : 8'd0);
    chk("locked", {7'd0, locked}, {7'd0, m_locked});
    chk("bit_error", {7'd0, bit_error}, {7'd0, e});
    chk("error_count", error_count, exp_q.pop_front());
  endtask

  task automatic src_bit(output logic b);
    b = pn_tab[src % 7];
    src++;
  endtask

  task automatic feed_good(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      src_bit(b);
      step(b, 1'b1, 1'b0);
    end
  endtask

  task automatic feed_bad(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      src_bit(b);
      step(~b, 1'b1, 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic b;
    logic v;
    logic c;
    repeat (2) @(posedge clk);
    do_reset();

    // clean sequence: lock on exactly the 10th valid bit
    feed_good(9);
    chk("lock_before_10th", {7'd0, locked}, 8'd0);
    feed_good(1);
    chk("lock_on_10th", {7'd0, locked}, 8'd1);
    chk("clean_count", error_count, 8'd0);
    feed_good(10);

    // one inverted bit -> one pulse, lock held
    feed_bad(1);
    chk("single_err_pulse", {7'd0, bit_error}, 8'd1);
    feed_good(1);
    chk("single_err_gone", {7'd0, bit_error}, 8'd0);
    chk("single_err_locked", {7'd0, locked}, 8'd1);
    chk("single_err_count", error_count, CNT_EN ? 8'd1 : 8'd0);
    feed_good(5);

    // clear, then three inverted bits -> loss on the third, relock 10 later
    src_bit(b);
    step(b, 1'b1, 1'b1);
    chk("clr_count", error_count, 8'd0);
    feed_bad(2);
    chk("two_miss_locked", {7'd0, locked}, 8'd1);
    feed_bad(1);
    chk("loss_on_third", {7'd0, locked}, 8'd0);
    chk("loss_count", error_count, CNT_EN ? 8'd3 : 8'd0);
    feed_good(9);
    chk("relock_early", {7'd0, locked}, 8'd0);
    feed_good(1);
    chk("relock_10th", {7'd0, locked}, 8'd1);

    // all-zero input never locks
    do_reset();
    for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 1'b0);
    chk("zero_no_lock", {7'd0, locked}, 8'd0);
    chk("zero_count", error_count, 8'd0);

    // pn_valid toggling: lock on the 10th valid bit
    do_reset();
    for (int i = 0; i < 9; i++) begin
      src_bit(b);
      step(b, 1'b1, 1'b0);
      step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
    chk("toggle_early", {7'd0, locked}, 8'd0);
    feed_good(1);
    chk("toggle_lock", {7'd0, locked}, 8'd1);

    // error flood: saturation, with one loss/relock on the way
    do_reset();
    feed_good(10);
    for (int i = 0; i < 160; i++) begin
      feed_bad(2);
      feed_good(1);
    end
    feed_bad(3);
    feed_good(10);
    chk("sat_count", error_count, CNT_EN ? 8'd255 : 8'd0);
    chk("sat_relocked", {7'd0, locked}, 8'd1);
    src_bit(b);
    step(~b, 1'b1, 1'b1);
    chk("clr_with_err", error_count, CNT_EN ? 8'd1 : 8'd0);
    feed_good(2);

    // reset while locked
    chk("pre_reset_locked", {7'd0, locked}, 8'd1);
    do_reset();

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 500) == 0) begin
        do_reset();
      end else begin
        v = ($urandom_range(0, 3) != 0);
        c = ($urandom_range(0, 40) == 0);
        if (v) begin
          src_bit(b);
          if ($urandom_range(0, 9) == 0) b = ~b;
          step(b, 1'b1, c);
        end else begin
          step(1'($urandom_range(0, 1)), 1'b0, c);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pn_seq_checker.md
PN_SEQ_CHECKER -- requirements
Module: pn_seq_checker

Interface
REQ-001 Parameter LOCK_CNT, default 7: consecutive correct predictions in SEARCH needed to declare lock.
REQ-002 Parameter LOSS_CNT, default 3: consecutive mispredictions in LOCKED needed to declare loss of lock.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pn_in  input  1  received serial PN bit from the upstream PN sequence generator.
REQ-006 pn_valid  input  1  pn_in is sampled only when high; tie high for one bit per clock.
REQ-007 err_clr  input  1  synchronous clear of error_count.
REQ-008 locked  output  1  high while in LOCKED state.
REQ-009 bit_error  output  1  one-cycle pulse per mispredicted bit while LOCKED.
REQ-010 error_count  output  8  saturating count of bit errors detected while LOCKED.

Function
REQ-011 The expected sequence SHALL obey s[n] = s[n-1] XOR s[n-3], the 3-bit LFSR sequence of period 7 (1,1,1,0,1,0,0 from seed 111).
REQ-012 The block SHALL keep a 3-bit history {s[n-1], s[n-2], s[n-3]}, a 2-bit fill counter, a match counter, and a miss counter.
REQ-013 States SHALL be SEARCH and LOCKED; reset enters SEARCH.
REQ-014 Cycles with pn_valid low SHALL leave all state, counters and history unchanged and keep bit_error low.
REQ-015 SEARCH, fill < 3: each valid bit SHALL shift into the history and increment fill; no comparison is made.
REQ-016 SEARCH, fill = 3: each valid bit SHALL be compared with the prediction; a match increments the match counter, a mismatch clears it; the received bit always shifts into the history.
REQ-017 A history of 000 SHALL make the comparison count as a mismatch, so the block never locks onto all-zeros.
REQ-018 When the match counter reaches LOCK_CNT, the block SHALL enter LOCKED, with locked high on the clock edge that samples that bit.
REQ-019 With defaults, the earliest lock SHALL occur on the 10th consecutive valid bit (3 fill + 7 matches).
REQ-020 LOCKED: the history SHALL shift in the predicted bit (flywheel), not pn_in, so one corrupted input bit yields exactly one error.
REQ-021 LOCKED, mismatch: bit_error SHALL pulse high for one cycle, registered one clock after the sample; error_count increments; the miss counter increments.
REQ-022 LOCKED, match: the miss counter SHALL clear.
REQ-023 When the miss counter reaches LOSS_CNT, the block SHALL return to SEARCH, with locked low from the edge sampling that bit; fill, match and miss counters clear, and that bit still counts as an error.
REQ-024 error_count SHALL saturate at 255.
REQ-025 err_clr SHALL take effect on the clock edge where it is sampled high.
REQ-026 If err_clr and an error coincide, error_count SHALL become 1.
REQ-027 Mismatches in SEARCH SHALL NOT pulse bit_error or change error_count.

Reset
REQ-028 On reset: state = SEARCH, history = 000, all counters = 0, locked = 0, bit_error = 0, error_count = 0.
REQ-029 Reset SHALL override pn_valid and err_clr.
REQ-030 Reset asserted while LOCKED SHALL drop locked on the next edge and require a full refill and relock.

Configuration
REQ-031 Macro PN_CHK_ERR_CNT_EN defined: error_count and its saturation/clear logic SHALL be built as specified.
REQ-032 Macro PN_CHK_ERR_CNT_EN undefined: error_count SHALL be driven constant 0 and err_clr ignored; locked and bit_error behaviour SHALL be unchanged.

Verification
REQ-033 Sequence 1110100 repeated, pn_valid=1 after reset -> locked rises on the 10th bit; bit_error stays 0; error_count = 0.
REQ-034 Once locked, invert one bit -> exactly one bit_error pulse; error_count = 1; locked stays high.
REQ-035 Once locked, invert 3 consecutive bits -> 3 bit_error pulses, locked falls on the 3rd; error_count = 3; relock 10 valid bits later.
REQ-036 All-zero input for 50 bits -> locked never rises; error_count = 0.
REQ-037 Valid sequence with pn_valid toggling 1/0 every cycle -> lock on the 10th valid bit, about 20 clocks.
REQ-038 Force 300 errors with periodic relock -> error_count holds at 255; err_clr coinciding with an error -> 1; reset while locked -> all outputs 0 next edge.
